// File: rtl/map_cnrom_prot_if.sv
// CPU/PPU/save-state bus between the cartridge decode logic and the CNROM mapper core.
// The master drives the bus inputs; the slave is the mapper and drives the memory-address outputs.
interface map_cnrom_prot_if #(
  parameter int CHR_BANK_BITS = 2
);
  logic [15:0]                 cpu_addr;
  logic [7:0]                  cpu_dat;
  logic                        cpu_rw;
  logic                        cpu_ce;
  logic [7:0]                  prg_dat;
  logic [13:0]                 ppu_addr;
  logic                        ss_act;
  logic                        ss_we;
  logic [7:0]                  ss_addr;
  logic [7:0]                  map_idx;
  logic [14:0]                 prg_addr;
  logic [13+CHR_BANK_BITS-1:0] chr_addr;
  logic                        chr_ce;
  logic                        chr_on;
  logic [7:0]                  ss_rdat;

  modport master (
    output cpu_addr, cpu_dat, cpu_rw, cpu_ce, prg_dat, ppu_addr,
           ss_act, ss_we, ss_addr, map_idx,
    input  prg_addr, chr_addr, chr_ce, chr_on, ss_rdat
  );

  modport slave (
    input  cpu_addr, cpu_dat, cpu_rw, cpu_ce, prg_dat, ppu_addr,
           ss_act, ss_we, ss_addr, map_idx,
    output prg_addr, chr_addr, chr_ce, chr_on, ss_rdat
  );
endinterface

// File: rtl/map_cnrom_prot.sv
// CNROM mapper with CHR copy-protection emulation (none / write-count unlock / keyed compare).
// Address outputs are combinational; bank/protection state updates on the m2 falling edge.
module map_cnrom_prot #(
  parameter int         CHR_BANK_BITS = 2,
  parameter int         PRG_32K       = 1,
  parameter int         PROT_MODE     = 1,
  parameter int         UNLOCK_WRITES = 2,
  parameter logic [1:0] PROT_KEY      = 2'b01,
  parameter int         BUS_CONFLICT  = 1
) (
  input logic              m2,
  input logic              map_rst,
  map_cnrom_prot_if.slave  bus
);

  localparam logic [3:0] UNLOCK_CNT = 4'(UNLOCK_WRITES);
  localparam logic       CHR_ON_RST = (PROT_MODE == 2) ? (PROT_KEY == 2'b00) : 1'b1;

  typedef enum logic [1:0] {
    PH_OPEN,
    PH_LOCKED,
    PH_UNLOCKED
  } phase_e;

  logic [CHR_BANK_BITS-1:0] chr_bank_q, chr_bank_d;
  logic [3:0]               wcnt_q, wcnt_d;
  logic                     chr_on_q, chr_on_d;
  phase_e                   phase;
  logic                     wr;
  logic [7:0]               wr_dat;
  logic                     unused_bits;

  assign wr     = !bus.cpu_ce && !bus.cpu_rw;
  assign wr_dat = (BUS_CONFLICT != 0) ? (bus.cpu_dat & bus.prg_dat) : bus.cpu_dat;

  assign bus.prg_addr[13:0] = bus.cpu_addr[13:0];
  assign bus.prg_addr[14]   = (PRG_32K != 0) ? bus.cpu_addr[14] : 1'b0;
  assign bus.chr_addr       = {chr_bank_q, bus.ppu_addr[12:0]};
  assign bus.chr_ce         = chr_on_q && !bus.ppu_addr[13];
  assign bus.chr_on         = chr_on_q;

  assign unused_bits = ^{bus.cpu_addr[15], wr_dat, bus.cpu_dat, bus.prg_dat};

  // Unlock phase is implied by the write count so a save-state restore lands in the right phase.
  always_comb begin
    phase = PH_OPEN;
    if (wcnt_q == 4'd0) begin
      phase = PH_OPEN;
    end else if (wcnt_q < UNLOCK_CNT) begin
      phase = PH_LOCKED;
    end else begin
      phase = PH_UNLOCKED;
    end
  end

  always_comb begin
    chr_bank_d = chr_bank_q;
    wcnt_d     = wcnt_q;
    chr_on_d   = chr_on_q;
    if (bus.ss_act) begin
      if (bus.ss_we && bus.ss_addr == 8'd0) begin
        wcnt_d   = bus.cpu_dat[4:1];
        chr_on_d = bus.cpu_dat[0];
      end else if (bus.ss_we && bus.ss_addr == 8'd1) begin
        chr_bank_d = bus.cpu_dat[CHR_BANK_BITS-1:0];
      end
    end else if (map_rst) begin
      chr_bank_d = '0;
      wcnt_d     = 4'd0;
      chr_on_d   = CHR_ON_RST;
    end else if (wr) begin
      chr_bank_d = wr_dat[CHR_BANK_BITS-1:0];
      if (PROT_MODE == 1) begin
        case (phase)
          PH_OPEN: begin
            wcnt_d   = 4'd1;
            chr_on_d = 1'b0;
          end
          PH_LOCKED: begin
            wcnt_d = wcnt_q + 4'd1;
            if (wcnt_q + 4'd1 == UNLOCK_CNT) begin
              chr_on_d = 1'b1;
            end
          end
          default: begin
            // Saturated: the count is never advanced again, so it cannot wrap.
            chr_on_d = 1'b1;
          end
        endcase
      end else if (PROT_MODE == 2) begin
        chr_on_d = (wr_dat[1:0] == PROT_KEY);
      end else begin
        chr_on_d = 1'b1;
      end
    end
  end

  always_ff @(negedge m2) begin
    chr_bank_q <= chr_bank_d;
    wcnt_q     <= wcnt_d;
    chr_on_q   <= chr_on_d;
  end

  always_comb begin
    bus.ss_rdat = 8'hFF;
    case (bus.ss_addr)
      8'd0:    bus.ss_rdat = {3'b000, wcnt_q, chr_on_q};
      8'd1:    bus.ss_rdat = 8'(chr_bank_q);
      8'd127:  bus.ss_rdat = bus.map_idx;
      default: bus.ss_rdat = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_map_cnrom_prot.sv
// Directed bench: four mapper instances (A: mode1/2 writes/conflict, B: mode1/4 writes,
// C: keyed mode, D: plain CNROM with 16 KB PRG) share one bus; cpu_ce/ss_act are per instance.
module tb_map_cnrom_prot;

  localparam int NI = 4;
  localparam int IA = 0;
  localparam int IB = 1;
  localparam int IC = 2;
  localparam int ID = 3;

  localparam logic [7:0]  MODE_V = {2'd0, 2'd2, 2'd1, 2'd1};
  localparam logic [15:0] UW_V   = {4'd2, 4'd2, 4'd4, 4'd2};
  localparam logic [3:0]  BC_V   = 4'b0001;
  localparam logic [3:0]  P32_V  = 4'b0111;

  logic        m2;
  logic        map_rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic        cpu_rw;
  logic [NI-1:0] ce_n;
  logic [7:0]  prg_dat;
  logic [13:0] ppu_addr;
  logic [NI-1:0] ss_act;
  logic        ss_we;
  logic [7:0]  ss_addr;
  logic [7:0]  map_idx;

  logic [14:0] prg_addr_w [NI];
  logic [14:0] chr_addr_w [NI];
  logic        chr_ce_w   [NI];
  logic        chr_on_w   [NI];
  logic [7:0]  ss_rdat_w  [NI];

  int n_run;
  int n_fail;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    map_cnrom_prot_if #(.CHR_BANK_BITS(2)) bus ();

    assign bus.cpu_addr = cpu_addr;
    assign bus.cpu_dat  = cpu_dat;
    assign bus.cpu_rw   = cpu_rw;
    assign bus.cpu_ce   = ce_n[g];
    assign bus.prg_dat  = prg_dat;
    assign bus.ppu_addr = ppu_addr;
    assign bus.ss_act   = ss_act[g];
    assign bus.ss_we    = ss_we;
    assign bus.ss_addr  = ss_addr;
    assign bus.map_idx  = map_idx;

    assign prg_addr_w[g] = bus.prg_addr;
    assign chr_addr_w[g] = bus.chr_addr;
    assign chr_ce_w[g]   = bus.chr_ce;
    assign chr_on_w[g]   = bus.chr_on;
    assign ss_rdat_w[g]  = bus.ss_rdat;

    map_cnrom_prot #(
      .CHR_BANK_BITS (2),
      .PRG_32K       (int'(P32_V[g])),
      .PROT_MODE     (int'(MODE_V[g*2 +: 2])),
      .UNLOCK_WRITES (int'(UW_V[g*4 +: 4])),
      .PROT_KEY      (2'b01),
      .BUS_CONFLICT  (int'(BC_V[g]))
    ) dut (
      .m2      (m2),
      .map_rst (map_rst),
      .bus     (bus.slave)
    );
  end

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_run++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One CPU write to $8000 on the selected instances, applied at the next falling edge.
  task automatic do_wr(input logic [NI-1:0] mask, input logic [7:0] dat, input logic [7:0] pd);
    @(posedge m2);
    cpu_addr = 16'h8000;
    cpu_dat  = dat;
    prg_dat  = pd;
    cpu_rw   = 1'b0;
    ce_n     = ~mask;
    @(negedge m2);
    #1;
    ce_n   = '1;
    cpu_rw = 1'b1;
  endtask

  function automatic logic [7:0] rd_ss(input int idx);
    return ss_rdat_w[idx];
  endfunction

  initial begin
    n_run    = 0;
    n_fail   = 0;
    map_rst  = 1'b1;
    cpu_addr = 16'h0000;
    cpu_dat  = 8'h00;
    cpu_rw   = 1'b1;
    ce_n     = '1;
    prg_dat  = 8'hFF;
    ppu_addr = 14'h0000;
    ss_act   = '0;
    ss_we    = 1'b0;
    ss_addr  = 8'd0;
    map_idx  = 8'd185;
    repeat (2) @(negedge m2);
    #1;
    map_rst = 1'b0;

    chk("rst_a_chr_on", 16'(chr_on_w[IA]), 16'h1);
    chk("rst_c_chr_on", 16'(chr_on_w[IC]), 16'h0);
    chk("rst_a_ss0", 16'(rd_ss(IA)), 16'h01);
    chk("rst_a_chr_ce", 16'(chr_ce_w[IA]), 16'h1);

    // Write-count unlock, two writes
    do_wr(4'b0001, 8'h03, 8'hFF);
    chk("a_w1_chr_on", 16'(chr_on_w[IA]), 16'h0);
    chk("a_w1_chr_ce", 16'(chr_ce_w[IA]), 16'h0);
    do_wr(4'b0001, 8'h02, 8'hFF);
    ppu_addr = 14'h0123;
    #1;
    chk("a_w2_chr_on", 16'(chr_on_w[IA]), 16'h1);
    chk("a_w2_chr_addr", 16'(chr_addr_w[IA]), 16'h4123);
    chk("a_w2_chr_ce", 16'(chr_ce_w[IA]), 16'h1);
    ppu_addr = 14'h2123;
    #1;
    chk("a_nt_chr_ce", 16'(chr_ce_w[IA]), 16'h0);
    ppu_addr = 14'h0000;
    for (int i = 0; i < 20; i++) do_wr(4'b0001, 8'h02, 8'hFF);
    chk("a_sat_chr_on", 16'(chr_on_w[IA]), 16'h1);
    chk("a_sat_ss0", 16'(rd_ss(IA)), 16'h05);

    // Write-count unlock, four writes
    for (int i = 0; i < 3; i++) begin
      do_wr(4'b0010, 8'h01, 8'hFF);
      chk("b_locked_chr_on", 16'(chr_on_w[IB]), 16'h0);
    end
    do_wr(4'b0010, 8'h01, 8'hFF);
    chk("b_w4_chr_on", 16'(chr_on_w[IB]), 16'h1);
    chk("b_w4_ss0", 16'(rd_ss(IB)), 16'h09);

    // Keyed compare
    do_wr(4'b0100, 8'h11, 8'hFF);
    chk("c_11_chr_on", 16'(chr_on_w[IC]), 16'h1);
    ss_addr = 8'd1;
    #1;
    chk("c_11_bank", 16'(rd_ss(IC)), 16'h01);
    do_wr(4'b0100, 8'h12, 8'hFF);
    chk("c_12_chr_on", 16'(chr_on_w[IC]), 16'h0);
    do_wr(4'b0100, 8'h21, 8'hFF);
    chk("c_21_chr_on", 16'(chr_on_w[IC]), 16'h1);

    // Bus conflict on A only; D takes raw data
    do_wr(4'b1001, 8'hFF, 8'h02);
    chk("a_bc_bank", 16'(rd_ss(IA)), 16'h02);
    chk("d_nobc_bank", 16'(rd_ss(ID)), 16'h03);
    chk("d_chr_on", 16'(chr_on_w[ID]), 16'h1);

    // Reset coincident with a write: the write must be dropped
    @(posedge m2);
    map_rst = 1'b1;
    do_wr(4'b0001, 8'h03, 8'hFF);
    map_rst = 1'b0;
    chk("rstwr_a_bank", 16'(rd_ss(IA)), 16'h00);
    ss_addr = 8'd0;
    #1;
    chk("rstwr_a_ss0", 16'(rd_ss(IA)), 16'h01);
    chk("rstwr_c_chr_on", 16'(chr_on_w[IC]), 16'h0);

    cpu_addr = 16'hC123;
    #1;
    chk("d_prg16k", 16'(prg_addr_w[ID]), 16'h0123);
    chk("a_prg32k", 16'(prg_addr_w[IA]), 16'h4123);

    // Save-state load on A with a concurrent CPU write that must be ignored
    @(posedge m2);
    ss_act  = 4'b0001;
    ss_we   = 1'b1;
    ss_addr = 8'd0;
    cpu_addr = 16'h8000;
    cpu_dat = 8'h03;
    prg_dat = 8'hFF;
    cpu_rw  = 1'b0;
    ce_n    = 4'b1110;
    @(negedge m2);
    #1;
    ss_we  = 1'b0;
    cpu_rw = 1'b1;
    ce_n   = '1;
    chk("ss_a_ss0", 16'(rd_ss(IA)), 16'h03);
    chk("ss_a_chr_on", 16'(chr_on_w[IA]), 16'h1);
    ss_addr = 8'd1;
    #1;
    chk("ss_a_bank", 16'(rd_ss(IA)), 16'h00);
    ss_addr = 8'd127;
    #1;
    chk("ss_a_mapidx", 16'(rd_ss(IA)), 16'h00B9);
    ss_addr = 8'd5;
    #1;
    chk("ss_a_idx5", 16'(rd_ss(IA)), 16'h00FF);
    ss_act  = '0;
    ss_addr = 8'd0;

    // Restored count of 1 resumes the unlock sequence
    do_wr(4'b0001, 8'h01, 8'hFF);
    chk("ss_resume_ss0", 16'(rd_ss(IA)), 16'h05);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/map_cnrom_prot.md
Name: map_cnrom_prot

Overview:
- Parametrised CNROM-family mapper core with CHR-ROM copy-protection emulation.
- Generalises the fixed two-write CHR-enable scheme:
  - configurable CHR bank width and PRG size;
  - selectable protection mode (none / write-count unlock / keyed compare);
  - optional bus-conflict emulation.
- Sits between the CPU/PPU bus decode and the PRG/CHR memory address/enable outputs.
- Register state is exposed through the save-state port.

Parameters:
- CHR_BANK_BITS, 2: width of the CHR bank register (1..4); CHR space is 8 KB * 2^CHR_BANK_BITS.
- PRG_32K, 1: 1 = 32 KB PRG; 0 = 16 KB mirrored (prg_addr[14] forced 0).
- PROT_MODE, 1: 0 = plain CNROM, CHR always on; 1 = write-count unlock; 2 = keyed compare.
- UNLOCK_WRITES, 2: in mode 1, the total number of ROM writes after reset at which CHR re-enables (2..15).
- PROT_KEY, 2'b01: in mode 2, CHR is on only while written data[1:0] == PROT_KEY.
- BUS_CONFLICT, 1: 1 = effective write data is cpu_dat & prg_dat.

Ports:
- m2, in, 1: system clock; all state updates on the falling edge.
- map_rst, in, 1: reset, synchronous, active-high, sampled on the m2 falling edge.
- cpu_addr, in, 16: CPU address.
- cpu_dat, in, 8: CPU write data.
- cpu_rw, in, 1: 1 = read, 0 = write.
- cpu_ce, in, 1: low = $8000-$FFFF ROM space.
- prg_dat, in, 8: PRG-ROM data at the current address, used for bus conflict.
- ppu_addr, in, 14: PPU address.
- ss_act, in, 1: save-state access active.
- ss_we, in, 1: save-state write strobe.
- ss_addr, in, 8: save-state register index.
- map_idx, in, 8: mapper number, returned at save-state index 127.
- prg_addr, out, 15: PRG-ROM address.
- chr_addr, out, 13+CHR_BANK_BITS: CHR-ROM address.
- chr_ce, out, 1: CHR chip enable; gated by protection and by ppu_addr[13]==0.
- chr_on, out, 1: protection status (1 = CHR readable).
- ss_rdat, out, 8: save-state read data.

Behaviour:
- Write strobe: wr = !cpu_ce & !cpu_rw.
  - Effective data d = BUS_CONFLICT ? (cpu_dat & prg_dat) : cpu_dat.
- Combinational address outputs:
  - prg_addr[12:0] = cpu_addr[12:0].
  - prg_addr[13] = cpu_addr[13].
  - prg_addr[14] = PRG_32K ? cpu_addr[14] : 0.
  - chr_addr = {chr_bank, ppu_addr[12:0]}.
  - chr_ce = chr_on & !ppu_addr[13].
- Reset (map_rst=1 at the m2 falling edge, ss_act=0):
  - chr_bank=0, wcnt=0.
  - chr_on=1 in modes 0 and 1.
  - chr_on=(0==PROT_KEY) in mode 2.
  - The reset is applied on the same edge; any write on that edge is ignored.
- Mode 0: on wr, chr_bank <= d[CHR_BANK_BITS-1:0]; chr_on held 1.
- Mode 1, state machine on wcnt (4 bits, saturating):
  - OPEN (wcnt=0): wr -> wcnt=1, chr_on=0, go LOCKED.
  - LOCKED (1 <= wcnt < UNLOCK_WRITES): wr -> wcnt++.
    - If the new wcnt == UNLOCK_WRITES: chr_on=1, go UNLOCKED.
  - UNLOCKED: wcnt saturates at UNLOCK_WRITES; further writes keep chr_on=1.
  - chr_bank is loaded from d on every wr in all states.
  - With UNLOCK_WRITES=2 this reproduces the legacy behaviour: on, off after the 1st write, on from the 2nd write onward.
- Mode 2: on wr, chr_bank <= d[CHR_BANK_BITS-1:0] and chr_on <= (d[1:0]==PROT_KEY). wcnt unused (held 0).
- PRG and RAM writes have no effect. Reads never change state.
- Save state: while ss_act=1, normal updates and reset are suppressed.
  - On ss_we, index 0 loads {wcnt, chr_on} from cpu_dat[4:0].
  - On ss_we, index 1 loads chr_bank from cpu_dat.
  - ss_rdat: index 0 = {3'b0, wcnt, chr_on}; index 1 = zero-extended chr_bank; index 127 = map_idx; all others 8'hFF.
- Saturation: wcnt never wraps, even after >15 writes.

Test Plan:
- Mode 1, UNLOCK_WRITES=2: reset, then write $8000=$03 -> chr_on=0, chr_ce=0 at ppu_addr=$0000. Second write $02 -> chr_on=1, chr_addr=$4000|ppu_addr. 20 further writes -> chr_on stays 1, wcnt=2.
- Mode 1, UNLOCK_WRITES=4: three writes keep chr_on=0; the 4th write sets chr_on=1.
- Mode 2, PROT_KEY=1: write $11 -> chr_on=1, bank=1. Write $12 -> chr_on=0. Write $21 -> chr_on=1.
- BUS_CONFLICT=1, cpu_dat=$FF, prg_dat=$02 -> chr_bank=2. Same case with BUS_CONFLICT=0 -> chr_bank=3 (2-bit bank).
- Simultaneous map_rst and wr with data $03 -> chr_bank=0, wcnt=0, chr_on=1. PRG_32K=0 with cpu_addr=$C123 -> prg_addr=$0123.
- Save state: ss_act=1, ss_we at index 0 with $03 -> wcnt=1, chr_on=1. A concurrent CPU write is ignored. Read-back: index 0 returns $03; index 127 returns map_idx; index 5 returns $FF.
